sensor_sched: RTL and testbench

- Round-robin scheduler that shares one isolation-tree scoring engine among NUM_CH serial-sensor input buffers.
- Watches each buffer's data_ready and captures the word from the granted channel.
- Launches the engine with a start pulse, waits for its done, publishes the anomaly result, then returns data_processed to the granted buffer.
- Sits between the per-sensor input buffers and the tree-traversal engine.

---
 rtl/sensor_sched.sv | 132 +++++++++++++
 tb/tb_sensor_sched.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_sched.sv
// rtl/sensor_sched.sv - round-robin scheduler sharing one scoring engine among NUM_CH sensor buffers
// Optional watchdog on the engine wait is compiled in with SCHED_TIMEOUT_EN.
module sensor_sched #(
    parameter int NUM_CH         = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int CH_W           = $clog2(NUM_CH),
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            ch_data_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
    output logic [NUM_CH-1:0]            ch_data_processed,
    output logic                         eng_start,
    output logic [DATA_WIDTH-1:0]        eng_data,
    output logic [CH_W-1:0]              eng_channel,
    input  logic                         eng_done,
    input  logic                         eng_anomaly,
    output logic                         result_valid,
    output logic [CH_W-1:0]              result_channel,
    output logic                         result_anomaly,
    output logic                         busy,
    output logic                         timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_ACK
    } state_t;

    localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

    state_t                  state;
    logic [CH_W-1:0]         last_grant;
    logic [CH_W-1:0]         sel;
    logic [CH_W-1:0]         idx_c;
    logic                    found;
    logic [DATA_WIDTH-1:0]   sel_data;

`ifdef SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt;
`endif

    // Search starts just after the last grant so every waiting requester is served once per round.
    always_comb begin
        sel   = '0;
        idx_c = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx_c = CH_W'((int'(last_grant) + i) % NUM_CH);
            if (!found && ch_data_ready[idx_c]) begin
                found = 1'b1;
                sel   = idx_c;
            end
        end
        sel_data = ch_data[sel*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= S_IDLE;
            last_grant        <= CH_W'(NUM_CH - 1);
            ch_data_processed <= '0;
            eng_start         <= 1'b0;
            eng_data          <= '0;
            eng_channel       <= '0;
            result_valid      <= 1'b0;
            result_channel    <= '0;
            result_anomaly    <= 1'b0;
            busy              <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            timeout_err       <= 1'b0;
            to_cnt            <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        eng_data    <= sel_data;
                        eng_channel <= sel;
                        last_grant  <= sel;
                        eng_start   <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    eng_start <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
                    to_cnt    <= '0;
`endif
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    // A done on the final watchdog cycle still counts as a normal result.
                    if (eng_done) begin
                        result_anomaly    <= eng_anomaly;
                        result_channel    <= eng_channel;
                        result_valid      <= 1'b1;
                        ch_data_processed <= ONE_HOT0 << eng_channel;
                        state             <= S_ACK;
                    end
`ifdef SCHED_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        ch_data_processed <= ONE_HOT0 << eng_channel;
                        timeout_err       <= 1'b1;
                        state             <= S_ACK;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                S_ACK: begin
                    ch_data_processed <= '0;
                    result_valid      <= 1'b0;
                    busy              <= 1'b0;
                    state             <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef SCHED_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_sensor_sched.sv
// tb/tb_sensor_sched.sv - directed table-driven bench for sensor_sched
module tb_sensor_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  ch_data_ready;
    logic [31:0] ch_data;
    logic [3:0]  ch_data_processed;
    logic        eng_start;
    logic [7:0]  eng_data;
    logic [1:0]  eng_channel;
    logic        eng_done;
    logic        eng_anomaly;
    logic        result_valid;
    logic [1:0]  result_channel;
    logic        result_anomaly;
    logic        busy;
    logic        timeout_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sensor_sched #(
        .NUM_CH(4),
        .DATA_WIDTH(8),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ch_data_ready(ch_data_ready),
        .ch_data(ch_data),
        .ch_data_processed(ch_data_processed),
        .eng_start(eng_start),
        .eng_data(eng_data),
        .eng_channel(eng_channel),
        .eng_done(eng_done),
        .eng_anomaly(eng_anomaly),
        .result_valid(result_valid),
        .result_channel(result_channel),
        .result_anomaly(result_anomaly),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic       rstn;
        logic [3:0] rdy;
        logic       done;
        logic       anom;
        logic       e_start;
        logic [3:0] e_ack;
        logic       e_rv;
        logic       e_busy;
        logic [1:0] e_ch;
        logic [7:0] e_dat;
        logic [1:0] e_rch;
        logic       e_ranom;
    } vec_t;

    vec_t vt[32];
    int   nv;

    function automatic vec_t mk(input logic rstn, input logic [3:0] rdy, input logic done,
                                input logic anom, input logic e_start, input logic [3:0] e_ack,
                                input logic e_rv, input logic e_busy, input logic [1:0] e_ch,
                                input logic [7:0] e_dat, input logic [1:0] e_rch,
                                input logic e_ranom);
        vec_t v;
        v.rstn = rstn; v.rdy = rdy; v.done = done; v.anom = anom;
        v.e_start = e_start; v.e_ack = e_ack; v.e_rv = e_rv; v.e_busy = e_busy;
        v.e_ch = e_ch; v.e_dat = e_dat; v.e_rch = e_rch; v.e_ranom = e_ranom;
        return v;
    endfunction

    function automatic logic [7:0] word_of(input int g);
        case (g)
            0: return 8'h11;
            1: return 8'h22;
            2: return 8'hD5;
            default: return 8'h44;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [1:0] prch;
        logic       pran;
        int         g;

        reset         = 1'b0;
        ch_data_ready = '0;
        ch_data       = 32'h44D5_2211;
        eng_done      = 1'b0;
        eng_anomaly   = 1'b0;

        nv = 0;
        vt[nv++] = mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 2'd0, 8'h00, 2'd0, 0);
        // single request on channel 2, engine done in the third WAIT cycle
        vt[nv++] = mk(1, 4'b0100, 0, 0, 1, 4'b0000, 0, 1, 2'd2, 8'hD5, 2'd0, 0);
        vt[nv++] = mk(1, 4'b0100, 0, 0, 0, 4'b0000, 0, 1, 2'd2, 8'hD5, 2'd0, 0);
        vt[nv++] = mk(1, 4'b0100, 0, 0, 0, 4'b0000, 0, 1, 2'd2, 8'hD5, 2'd0, 0);
        vt[nv++] = mk(1, 4'b0100, 0, 0, 0, 4'b0000, 0, 1, 2'd2, 8'hD5, 2'd0, 0);
        vt[nv++] = mk(1, 4'b0100, 1, 1, 0, 4'b0100, 1, 1, 2'd2, 8'hD5, 2'd2, 1);
        vt[nv++] = mk(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 2'd2, 8'hD5, 2'd2, 1);
        vt[nv++] = mk(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 2'd2, 8'hD5, 2'd2, 1);
        vt[nv++] = mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 2'd0, 8'h00, 2'd0, 0);
        // all four ready, done also raised during LAUNCH where it must be ignored
        prch = 2'd0;
        pran = 1'b0;
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            vt[nv++] = mk(1, 4'b1111, 0, 0, 1, 4'b0000, 0, 1, 2'(g), word_of(g), prch, pran);
            vt[nv++] = mk(1, 4'b1111, 1, g[0], 0, 4'b0000, 0, 1, 2'(g), word_of(g), prch, pran);
            vt[nv++] = mk(1, 4'b1111, 1, g[0], 0, 4'(1 << g), 1, 1, 2'(g), word_of(g), 2'(g), g[0]);
            vt[nv++] = mk(1, 4'b1111, 0, 0, 0, 4'b0000, 0, 0, 2'(g), word_of(g), 2'(g), g[0]);
            prch = 2'(g);
            pran = g[0];
        end

        for (int i = 0; i < nv; i++) begin
            reset         = vt[i].rstn;
            ch_data_ready = vt[i].rdy;
            eng_done      = vt[i].done;
            eng_anomaly   = vt[i].anom;
            step();
            check($sformatf("v%0d.start", i), 32'(eng_start), 32'(vt[i].e_start));
            check($sformatf("v%0d.ack", i), 32'(ch_data_processed), 32'(vt[i].e_ack));
            check($sformatf("v%0d.rvalid", i), 32'(result_valid), 32'(vt[i].e_rv));
            check($sformatf("v%0d.busy", i), 32'(busy), 32'(vt[i].e_busy));
            check($sformatf("v%0d.rch", i), 32'(result_channel), 32'(vt[i].e_rch));
            check($sformatf("v%0d.ranom", i), 32'(result_anomaly), 32'(vt[i].e_ranom));
            check($sformatf("v%0d.terr", i), 32'(timeout_err), 32'd0);
            if (vt[i].e_busy || !vt[i].rstn) begin
                check($sformatf("v%0d.ech", i), 32'(eng_channel), 32'(vt[i].e_ch));
                check($sformatf("v%0d.edata", i), 32'(eng_data), 32'(vt[i].e_dat));
            end
        end

        // reset during WAIT on channel 1
        ch_data_ready = 4'b0000;
        eng_done      = 1'b0;
        reset_pulse();
        ch_data_ready = 4'b0010;
        step();
        step();
        step();
        check("rst_wait.busy_before", 32'(busy), 32'd1);
        check("rst_wait.ch_before", 32'(eng_channel), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_wait.busy", 32'(busy), 32'd0);
        check("rst_wait.ack", 32'(ch_data_processed), 32'd0);
        check("rst_wait.rvalid", 32'(result_valid), 32'd0);
        check("rst_wait.edata", 32'(eng_data), 32'd0);
        check("rst_wait.ech", 32'(eng_channel), 32'd0);
        ch_data_ready = 4'b0011;
        #1;
        reset = 1'b1;
        step();
        check("rst_wait.regrant_ch", 32'(eng_channel), 32'd0);
        check("rst_wait.regrant_start", 32'(eng_start), 32'd1);
        ch_data_ready = 4'b0000;
        step();
        eng_done = 1'b1;
        step();
        check("rst_wait.regrant_ack", 32'(ch_data_processed), 32'b0001);
        eng_done = 1'b0;
        step();

        // granted channel 3 drops its ready flag mid-transaction
        reset_pulse();
        ch_data_ready = 4'b1000;
        step();
        check("drop.ch", 32'(eng_channel), 32'd3);
        step();
        ch_data_ready = 4'b0000;
        step();
        eng_done    = 1'b1;
        eng_anomaly = 1'b0;
        step();
        check("drop.ack", 32'(ch_data_processed), 32'b1000);
        check("drop.rvalid", 32'(result_valid), 32'd1);
        check("drop.rch", 32'(result_channel), 32'd3);
        eng_done = 1'b0;
        step();
        check("drop.idle_ack", 32'(ch_data_processed), 32'd0);
        check("drop.idle_busy", 32'(busy), 32'd0);

`ifdef SCHED_TIMEOUT_EN
        // watchdog expiry after ten WAIT cycles
        reset_pulse();
        ch_data_ready = 4'b0001;
        step();
        ch_data_ready = 4'b0000;
        step();
        for (int k = 1; k <= 9; k++) begin
            step();
            check($sformatf("to.wait%0d_ack", k), 32'(ch_data_processed), 32'd0);
        end
        step();
        check("to.ack", 32'(ch_data_processed), 32'b0001);
        check("to.rvalid", 32'(result_valid), 32'd0);
        check("to.terr", 32'(timeout_err), 32'd1);
        step();
        check("to.terr_sticky", 32'(timeout_err), 32'd1);
        ch_data_ready = 4'b0010;
        step();
        ch_data_ready = 4'b0000;
        step();
        eng_done = 1'b1;
        step();
        check("to.next_rvalid", 32'(result_valid), 32'd1);
        check("to.next_rch", 32'(result_channel), 32'd1);
        check("to.next_terr", 32'(timeout_err), 32'd1);
        eng_done = 1'b0;
        step();

        // done on the limit cycle wins over the watchdog
        reset_pulse();
        check("lim.terr_reset", 32'(timeout_err), 32'd0);
        ch_data_ready = 4'b0001;
        step();
        ch_data_ready = 4'b0000;
        step();
        repeat (9) step();
        eng_done    = 1'b1;
        eng_anomaly = 1'b1;
        step();
        check("lim.ack", 32'(ch_data_processed), 32'b0001);
        check("lim.rvalid", 32'(result_valid), 32'd1);
        check("lim.ranom", 32'(result_anomaly), 32'd1);
        check("lim.terr", 32'(timeout_err), 32'd0);
        eng_done = 1'b0;
        step();
`else
        // without the watchdog a long wait never times out
        reset_pulse();
        ch_data_ready = 4'b0001;
        step();
        ch_data_ready = 4'b0000;
        step();
        repeat (20) step();
        check("nowd.busy", 32'(busy), 32'd1);
        check("nowd.ack", 32'(ch_data_processed), 32'd0);
        check("nowd.terr", 32'(timeout_err), 32'd0);
        eng_done = 1'b1;
        step();
        check("nowd.rvalid", 32'(result_valid), 32'd1);
        check("nowd.done_ack", 32'(ch_data_processed), 32'b0001);
        eng_done = 1'b0;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
